// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the Segway A2D sweep sequencer.
//   a2d_state_t      : sweep FSM state encoding
//   A2D_CMD_CH_LSB   : bit position of the 3-bit channel address in an SPI command
//   DEFAULT_CH_MAP   : default packed channel-address table (3 bits per index)
//   BATT_LOW_THRESH  : level below which the monitored channel reads "low"
//   BATT_HIGH_THRESH : level at or above which the low flag is released
//   a2d_cmd()        : builds the 16-bit conversion command for one channel
// ---------------------------------------------------------------------------
package seg_pkg;

   typedef enum logic [2:0] {
      A2D_IDLE,
      A2D_CONV,
      A2D_WAIT_C,
      A2D_GAP,
      A2D_READ,
      A2D_WAIT_R,
      A2D_NEXT
   } a2d_state_t;

   localparam int          A2D_CMD_CH_LSB   = 11;
   localparam logic [23:0] DEFAULT_CH_MAP   = 24'h000543;
   localparam logic [11:0] BATT_LOW_THRESH  = 12'h800;
   localparam logic [11:0] BATT_HIGH_THRESH = 12'h840;

   // Command word is {2'b00, channel, 11'h000}
   function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
      return 16'(ch) << A2D_CMD_CH_LSB;
   endfunction

endpackage

// File: rtl/iir_shift_filt.sv
// ---------------------------------------------------------------------------
// iir_shift_filt
// Combinational single-pole IIR update, shared by all channels of a sweep.
//   y_i      : previous filtered value
//   s_i      : new raw sample
//   seeded_i : 0 = first sweep after reset, pass the raw sample through
//   y_o      : updated filtered value, y + ((s - y) >>> AVG_LOG2)
// ---------------------------------------------------------------------------
module iir_shift_filt #(
   parameter int DW       = 12,
   parameter int AVG_LOG2 = 0
) (
   input  logic [DW-1:0] y_i,
   input  logic [DW-1:0] s_i,
   input  logic          seeded_i,
   output logic [DW-1:0] y_o
);

   logic signed [DW:0] diff;
   logic signed [DW:0] step;
   logic signed [DW:0] sum;

   // The arithmetic shift rounds toward minus infinity, so the step never
   // overshoots the sample in either direction; y + step therefore always
   // lands between y and s and cannot wrap at 0 or at all-ones.
   always_comb begin
      diff = $signed({1'b0, s_i}) - $signed({1'b0, y_i});
      step = diff >>> AVG_LOG2;
      sum  = $signed({1'b0, y_i}) + step;
      if (seeded_i) begin
         y_o = DW'(sum);
      end else begin
         y_o = s_i;
      end
   end

endmodule

// File: rtl/a2d_chan_seq.sv
// ---------------------------------------------------------------------------
// a2d_chan_seq
// Sweeps NUM_CH A2D channels through the SPI master on every nxt pulse,
// IIR-filters each result and keeps a hysteretic low flag on one channel.
//   clk_i       : system clock
//   rst_i       : synchronous active-high reset
//   nxt_i       : start-of-sweep pulse
//   wrt_o       : one-cycle start pulse to the SPI master
//   cmd_o       : SPI command word
//   done_i      : SPI transaction complete pulse
//   rd_data_i   : SPI returned word (valid with done_i)
//   rslt_o      : filtered results, channel i at [DW*i +: DW]
//   rslt_vld_o  : one-cycle pulse, sweep finished and rslt_o updated
//   busy_o      : sweep in progress (through the rslt_vld_o cycle)
//   ovrn_o      : nxt_i arrived while busy and was dropped
//   mon_low_o   : hysteretic low flag on channel MON_CH
// ---------------------------------------------------------------------------
module a2d_chan_seq
   import seg_pkg::*;
#(
   parameter int            NUM_CH    = 4,
   parameter int            DW        = 12,
   parameter logic [23:0]   CH_MAP    = DEFAULT_CH_MAP,
   parameter int            AVG_LOG2  = 0,
   parameter int            MON_CH    = 2,
   parameter logic [DW-1:0] LO_THRESH = DW'(BATT_LOW_THRESH),
   parameter logic [DW-1:0] HI_THRESH = DW'(BATT_HIGH_THRESH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 nxt_i,
   output logic                 wrt_o,
   output logic [15:0]          cmd_o,
   input  logic                 done_i,
   input  logic [15:0]          rd_data_i,
   output logic [NUM_CH*DW-1:0] rslt_o,
   output logic                 rslt_vld_o,
   output logic                 busy_o,
   output logic                 ovrn_o,
   output logic                 mon_low_o
);

   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   a2d_state_t           state_q,   state_d;
   logic [IW-1:0]        idx_q,     idx_d;
   logic                 wrt_q,     wrt_d;
   logic [15:0]          cmd_q,     cmd_d;
   logic [NUM_CH*DW-1:0] rslt_q,    rslt_d;
   logic                 rsltVld_q, rsltVld_d;
   logic                 busy_q,    busy_d;
   logic                 monLow_q,  monLow_d;
   logic                 seeded_q,  seeded_d;
   logic [DW-1:0]        samp_q,    samp_d;
   logic [DW-1:0]        filtY;
   logic [DW-1:0]        monVal;

   function automatic logic [15:0] chanCmd(input logic [IW-1:0] idx);
      logic [2:0] addr;
      addr = CH_MAP[3*int'(idx) +: 3];
      return a2d_cmd(addr);
   endfunction

   iir_shift_filt #(
      .DW       (DW),
      .AVG_LOG2 (AVG_LOG2)
   ) uFilt (
      .y_i      (rslt_q[int'(idx_q)*DW +: DW]),
      .s_i      (samp_q),
      .seeded_i (seeded_q),
      .y_o      (filtY)
   );

   assign monVal = rslt_q[MON_CH*DW +: DW];

   // Next-state logic. wrt/cmd are registered and loaded on entry to
   // CONV/READ so the pulse lines up exactly with those states. The low flag
   // and the seeded marker are settled in the rslt_vld cycle, when rslt_q
   // already holds the finished sweep.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wrt_d     = 1'b0;
      cmd_d     = cmd_q;
      rslt_d    = rslt_q;
      rsltVld_d = 1'b0;
      busy_d    = busy_q;
      monLow_d  = monLow_q;
      seeded_d  = seeded_q;
      samp_d    = samp_q;
      case (state_q)
         A2D_IDLE: begin
            if (rsltVld_q) begin
               busy_d   = 1'b0;
               seeded_d = 1'b1;
               if (monVal < LO_THRESH) begin
                  monLow_d = 1'b1;
               end else if (monVal >= HI_THRESH) begin
                  monLow_d = 1'b0;
               end
            end
            if (nxt_i && !busy_q) begin
               state_d = A2D_CONV;
               idx_d   = '0;
               busy_d  = 1'b1;
               wrt_d   = 1'b1;
               cmd_d   = chanCmd('0);
            end
         end
         A2D_CONV: begin
            state_d = A2D_WAIT_C;
         end
         A2D_WAIT_C: begin
            if (done_i) begin
               state_d = A2D_GAP;
            end
         end
         A2D_GAP: begin
            state_d = A2D_READ;
            wrt_d   = 1'b1;
         end
         A2D_READ: begin
            state_d = A2D_WAIT_R;
         end
         A2D_WAIT_R: begin
            if (done_i) begin
               samp_d  = DW'(rd_data_i);
               state_d = A2D_NEXT;
            end
         end
         A2D_NEXT: begin
            rslt_d[int'(idx_q)*DW +: DW] = filtY;
            if (idx_q == IW'(NUM_CH-1)) begin
               state_d   = A2D_IDLE;
               rsltVld_d = 1'b1;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = A2D_CONV;
               wrt_d   = 1'b1;
               cmd_d   = chanCmd(idx_q + 1'b1);
            end
         end
         default: begin
            state_d = A2D_IDLE;
         end
      endcase
   end

   // State register; reset discards any partial sweep and forces re-seeding
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= A2D_IDLE;
         idx_q     <= '0;
         wrt_q     <= 1'b0;
         cmd_q     <= '0;
         rslt_q    <= '0;
         rsltVld_q <= 1'b0;
         busy_q    <= 1'b0;
         monLow_q  <= 1'b0;
         seeded_q  <= 1'b0;
         samp_q    <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wrt_q     <= wrt_d;
         cmd_q     <= cmd_d;
         rslt_q    <= rslt_d;
         rsltVld_q <= rsltVld_d;
         busy_q    <= busy_d;
         monLow_q  <= monLow_d;
         seeded_q  <= seeded_d;
         samp_q    <= samp_d;
      end
   end

   assign wrt_o      = wrt_q;
   assign cmd_o      = cmd_q;
   assign rslt_o     = rslt_q;
   assign rslt_vld_o = rsltVld_q;
   assign busy_o     = busy_q;
   assign mon_low_o  = monLow_q;
   assign ovrn_o     = nxt_i & busy_q;

endmodule

// File: tb/tb_a2d_chan_seq.sv
// ---------------------------------------------------------------------------
// tb_a2d_chan_seq
// Drives sweeps of a2d_chan_seq against an SPI slave model and compares the
// results with a behavioural filter/threshold model through a scoreboard.
// ---------------------------------------------------------------------------
module tb_a2d_chan_seq;
   import seg_pkg::*;

   localparam int            NUM_CH  = 4;
   localparam int            DW      = 12;
   localparam int            AVG     = 2;
   localparam int            MON     = 2;
   localparam int            SPI_LAT = 8;
   // Map chosen so the sweep addresses channels 3,4,5,0
   localparam logic [23:0]   MAP     = 24'h000163;
   localparam logic [DW-1:0] LO      = 12'h800;
   localparam logic [DW-1:0] HI      = 12'h840;
   localparam int            LATENCY = NUM_CH*(2*SPI_LAT+4)+1;

   logic                 clk = 1'b0;
   logic                 rst, nxt, done;
   logic [15:0]          rd_data;
   logic                 wrt, rsltVld, busy, ovrn, monLow;
   logic [15:0]          cmd;
   logic [NUM_CH*DW-1:0] rslt;

   a2d_chan_seq #(
      .NUM_CH    (NUM_CH),
      .DW        (DW),
      .CH_MAP    (MAP),
      .AVG_LOG2  (AVG),
      .MON_CH    (MON),
      .LO_THRESH (LO),
      .HI_THRESH (HI)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .nxt_i      (nxt),
      .wrt_o      (wrt),
      .cmd_o      (cmd),
      .done_i     (done),
      .rd_data_i  (rd_data),
      .rslt_o     (rslt),
      .rslt_vld_o (rsltVld),
      .busy_o     (busy),
      .ovrn_o     (ovrn),
      .mon_low_o  (monLow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [NUM_CH*DW-1:0] rslt;
      bit                   mon;
      int                   startCyc;
   } exp_t;

   exp_t          expQ[$];
   logic [15:0]   cmdQ[$];
   int            total = 0;
   int            bad = 0;
   int            wrtCount = 0;
   bit            spiClear = 0;
   bit            strayIdleReq = 0;
   bit            strayGap = 0;
   logic [DW-1:0] sampByAddr[8];
   logic [DW-1:0] chSamp[NUM_CH];
   int            yMod[NUM_CH];
   bit            seededMod = 0;
   bit            monMod = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int addrOf(input int i);
      logic [23:0] m;
      m = MAP;
      return int'(m[3*i +: 3]);
   endfunction

   // floor((d) / 2^AVG) in plain integer arithmetic
   function automatic int floorDiv(input int d);
      int p;
      p = 1 << AVG;
      if (d >= 0) return d / p;
      return -((-d + p - 1) / p);
   endfunction

   // SPI slave: each transaction completes SPI_LAT clocks after wrt, the
   // second of each pair returns the sample for the addressed channel
   initial begin
      int         cnt;
      bit         phase;
      bit         strayNext;
      logic [2:0] addr;
      cnt = 0; phase = 0; strayNext = 0; addr = '0;
      done = 1'b0;
      rd_data = '0;
      forever begin
         @(negedge clk);
         done = 1'b0;
         if (spiClear) begin
            cnt = 0; phase = 0; strayNext = 0; spiClear = 0;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               done = 1'b1;
               rd_data = phase ? {4'($urandom), sampByAddr[addr]} : 16'($urandom);
               if (!phase && strayGap) strayNext = 1;
               phase = !phase;
            end
         end else if (strayNext) begin
            done = 1'b1;
            rd_data = 16'($urandom);
            strayNext = 0;
         end else if (wrt) begin
            if (cmdQ.size() == 0) begin
               total++; bad++;
               $display("[TB] FAIL unexpected_wrt: got cmd %0h expected none", cmd);
            end else begin
               checkOutput("cmd", 64'(cmd), 64'(cmdQ.pop_front()));
            end
            addr = cmd[13:11];
            cnt = SPI_LAT;
            wrtCount++;
         end else if (strayIdleReq && !busy) begin
            done = 1'b1;
            rd_data = 16'($urandom);
            strayIdleReq = 0;
         end
      end
   end

   // Monitor: pops the scoreboard on each rslt_vld, checks the low flag a
   // cycle later once it has been updated
   initial begin
      bit   monPending;
      exp_t cur;
      monPending = 0;
      forever begin
         @(negedge clk);
         if (monPending) begin
            checkOutput("mon_low", 64'(monLow), 64'(cur.mon));
            checkOutput("busy_after_vld", 64'(busy), 64'd0);
            monPending = 0;
         end
         if (rsltVld) begin
            if (expQ.size() == 0) begin
               total++; bad++;
               $display("[TB] FAIL unexpected_rslt_vld: got pulse expected none");
            end else begin
               cur = expQ.pop_front();
               checkOutput("rslt", 64'(rslt), 64'(cur.rslt));
               checkOutput("latency", 64'(cyc - cur.startCyc), 64'(LATENCY));
               checkOutput("busy_in_vld", 64'(busy), 64'd1);
               monPending = 1;
            end
         end
      end
   end

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      nxt = 1'b0;
      spiClear = 1;
      cmdQ.delete();
      expQ.delete();
      seededMod = 0;
      monMod = 0;
      for (int i = 0; i < NUM_CH; i++) yMod[i] = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Update the reference model for one sweep and queue its expectations
   task automatic modelSweep(output exp_t e);
      for (int i = 0; i < NUM_CH; i++) begin
         sampByAddr[addrOf(i)] = chSamp[i];
         if (!seededMod) yMod[i] = int'(chSamp[i]);
         else yMod[i] = yMod[i] + floorDiv(int'(chSamp[i]) - yMod[i]);
         e.rslt[i*DW +: DW] = DW'(yMod[i]);
         cmdQ.push_back(a2d_cmd(3'(addrOf(i))));
         cmdQ.push_back(a2d_cmd(3'(addrOf(i))));
      end
      if (yMod[MON] < int'(LO)) monMod = 1;
      else if (yMod[MON] >= int'(HI)) monMod = 0;
      seededMod = 1;
      e.mon = monMod;
   endtask

   task automatic applyStimulus(input int nOvrn, input bit strayIdle, input bit strayG);
      exp_t e;
      int   t;
      modelSweep(e);
      strayGap = strayG;
      if (strayIdle) begin
         strayIdleReq = 1;
         repeat (3) @(negedge clk);
      end
      @(negedge clk);
      nxt = 1'b1;
      e.startCyc = cyc;
      expQ.push_back(e);
      #1 checkOutput("ovrn_on_accept", 64'(ovrn), 64'd0);
      @(negedge clk);
      nxt = 1'b0;
      for (int k = 0; k < nOvrn; k++) begin
         repeat (7 + $urandom_range(0, 10)) @(negedge clk);
         nxt = 1'b1;
         #1 checkOutput("ovrn_when_busy", 64'(ovrn), 64'd1);
         @(negedge clk);
         nxt = 1'b0;
      end
      t = 0;
      while (busy && t < 400) begin
         @(negedge clk);
         t++;
      end
      checkOutput("sweep_timeout", 64'(busy), 64'd0);
      @(negedge clk);
      strayGap = 0;
   endtask

   initial begin
      logic [DW-1:0] hystIn[5];
      bit            hystExp[5];
      logic [DW-1:0] filtExp[3];
      logic [DW-1:0] prev;
      logic [DW-1:0] cur;
      exp_t          e;
      int            t;
      rst = 1'b1;
      nxt = 1'b0;
      applyReset();
      checkOutput("reset_rslt", 64'(rslt), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_wrt", 64'(wrt), 64'd0);
      checkOutput("reset_cmd", 64'(cmd), 64'd0);
      checkOutput("reset_vld", 64'(rsltVld), 64'd0);
      checkOutput("reset_mon", 64'(monLow), 64'd0);

      $display("[TB] first sweep seeds raw samples");
      chSamp = '{12'h111, 12'h222, 12'h333, 12'h444};
      applyStimulus(0, 0, 0);
      checkOutput("seed_values", 64'(rslt), 64'h444333222111);

      $display("[TB] overrun pulses during a sweep");
      for (int i = 0; i < NUM_CH; i++) chSamp[i] = DW'($urandom);
      applyStimulus(2, 0, 0);

      $display("[TB] filter step response");
      applyReset();
      chSamp = '{12'h400, 12'h400, 12'h400, 12'h400};
      applyStimulus(0, 0, 0);
      filtExp = '{12'h500, 12'h5C0, 12'h650};
      chSamp = '{12'h800, 12'h800, 12'h800, 12'h800};
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 0, 0);
         if (k < 3) checkOutput("step_value", 64'(rslt[DW-1:0]), 64'(filtExp[k]));
         checkOutput("step_bound", 64'(rslt[DW-1:0] <= 12'h800), 64'd1);
      end

      $display("[TB] filter decay to zero");
      applyReset();
      chSamp = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
      applyStimulus(0, 0, 0);
      prev = rslt[DW-1:0];
      chSamp = '{12'h000, 12'h000, 12'h000, 12'h000};
      for (int k = 0; k < 40; k++) begin
         applyStimulus(0, 0, 0);
         cur = rslt[DW-1:0];
         checkOutput("decay_monotone", 64'(cur <= prev), 64'd1);
         prev = cur;
      end
      checkOutput("decay_floor", 64'(rslt[DW-1:0]), 64'd0);

      $display("[TB] low-flag hysteresis");
      applyReset();
      // Filtered monitor channel becomes 900, 7FF, 820, 83F, 840
      hystIn  = '{12'h900, 12'h4FC, 12'h883, 12'h89C, 12'h843};
      hystExp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < NUM_CH; i++) chSamp[i] = DW'($urandom);
         chSamp[MON] = hystIn[k];
         applyStimulus(0, 0, 0);
         checkOutput("hyst_flag", 64'(monLow), 64'(hystExp[k]));
      end

      $display("[TB] stray done in IDLE and GAP");
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NUM_CH; i++) chSamp[i] = DW'($urandom);
         applyStimulus(0, 1, 1);
      end

      $display("[TB] reset during ch2 read");
      for (int i = 0; i < NUM_CH; i++) chSamp[i] = DW'($urandom);
      modelSweep(e);
      t = wrtCount;
      @(negedge clk);
      nxt = 1'b1;
      @(negedge clk);
      nxt = 1'b0;
      while (wrtCount < t + 6 && wrtCount >= t && t > -1 && busy) @(negedge clk);
      checkOutput("ch2_read_reached", 64'(wrtCount - t), 64'd6);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      spiClear = 1;
      cmdQ.delete();
      seededMod = 0;
      monMod = 0;
      for (int i = 0; i < NUM_CH; i++) yMod[i] = 0;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_wrt", 64'(wrt), 64'd0);
      checkOutput("abort_rslt", 64'(rslt), 64'd0);
      for (int i = 0; i < NUM_CH; i++) chSamp[i] = DW'($urandom);
      applyStimulus(0, 0, 0);
      for (int i = 0; i < NUM_CH; i++)
         checkOutput("reseed_raw", 64'(rslt[i*DW +: DW]), 64'(chSamp[i]));

      $display("[TB] randomized sweeps");
      for (int k = 0; k < 15; k++) begin
         for (int i = 0; i < NUM_CH; i++) chSamp[i] = DW'($urandom);
         if ($urandom_range(0, 3) == 0) chSamp[MON] = DW'(12'h7F0 + $urandom_range(0, 96));
         applyStimulus($urandom_range(0, 2), 1'($urandom), 1'($urandom));
      end

      repeat (5) @(negedge clk);
      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
      checkOutput("cmds_drained", 64'(cmdQ.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no completion expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
